dsi_packet_assembler: RTL and testbench
=======================================

// Module: dsi_packet_assembler
// PURPOSE
//  Builds DSI short/long packets from a command + payload stream and feeds the lanes controller's
//  32-bit word interface (iface_write_*). Computes header ECC and payload CRC16, appends CRC and
//  marks valid bytes of the final word. Byte 0 (bits [7:0]) of every word goes out first (lane 0).
// PARAMETERS
//  CRC_ENABLE  1  1: real CRC16; 0: CRC bytes sent as 16'h0000
//  ECC_ENABLE  1  1: real ECC; 0: ECC byte sent as 8'h00
// PORTS
//  clk_sys          in   1   system clock
//  rst_n            in   1   asynchronous reset, active-low
//  link_ready       in   1   lanes up (from lines_ready); a packet starts only when 1
//  pkt_valid        in   1   command valid
//  pkt_ready        out  1   command accepted when pkt_valid && pkt_ready
//  pkt_long         in   1   1 = long packet, 0 = short packet
//  pkt_lp_mode      in   1   copied to iface_write_strb[4] for all words of the packet
//  pkt_vc           in   2   virtual channel -> header byte0[7:6]
//  pkt_data_type    in   6   data ID -> header byte0[5:0]
//  pkt_word_count   in   16  long: payload byte count WC; short: the two data bytes
//  payload_data     in   32  payload word, little-endian byte order
//  payload_valid    in   1   payload word available
//  payload_ready    out  1   payload word consumed when payload_valid && payload_ready
//  iface_write_data out  32  word to lanes controller
//  iface_write_strb out  5   [3:0] byte valid, [4] LP mode flag
//  iface_write_rqst out  1   held high from first word until last word consumed
//  iface_last_word  out  1   current word is the last of the packet
//  iface_data_rqst  in   1   downstream takes current word this cycle
//  payload_underrun out  1   1-cycle pulse: word taken while next payload word absent
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, partial packet discarded; same on reset mid-packet.
//  Word consumed: cycle with iface_write_rqst && iface_data_rqst. Output regs load the next word that edge.
//  FSM: IDLE -> HDR (pkt_valid && link_ready, pkt_ready=1 that cycle only, command latched)
//   HDR: data = {ECC, WC[15:8], WC[7:0], VC:DT}, strb 4'hF, rqst=1 from cycle after accept.
//   Short: last_word=1 in HDR; on consume -> IDLE. Long, WC=0: on consume -> CRC.
//   Long, WC>0: on consume -> PAY.
//   PAY: N=ceil(WC/4) words; each consume pulls one payload word (payload_ready=1 combinationally
//    when consume && payload_valid). Final payload word keeps r=WC%4 bytes (r=0 -> 4); unused bytes = 0.
//   CRC placement in final word: r=1 bytes[2:1], strb 4'h7, last; r=2 bytes[3:2], strb 4'hF, last;
//    r=3 CRC[7:0] in byte3, strb 4'hF, then CRC state: byte0=CRC[15:8], strb 4'h1, last;
//    r=4 (full) -> CRC state: bytes[1:0]=CRC, strb 4'h3, last.
//   CRC state: on consume -> IDLE. rqst drops the cycle after the last word is consumed.
//  Total words = ceil((6+WC)/4) long, 1 short. Back-to-back: IDLE may accept next command the cycle
//   after last consume (1 idle cycle between packets, rqst low there).
//  ECC: DSI 24-bit Hamming, P5..P0 over header bytes 0-2, ECC[7:6]=0.
//  CRC16: poly x^16+x^12+x^5+1 reflected (0x8408), init 16'hFFFF, LSB-first, no final XOR,
//   over payload bytes only; 4 bytes/cycle combinational update, masked to valid bytes.
//  Underrun: if consume in PAY needs a payload word and payload_valid=0: pulse payload_underrun,
//   output word frozen, rqst stays high, word count not advanced; resume when payload_valid=1.
//  pkt_* changes while not accepted are ignored; link_ready drop mid-packet does not abort.
// TESTING
//  Short 05/11/00 VC0, data_rqst always 1 -> one word 32'h36_00_11_05, strb 5'h0F, last=1.
//  Short 05/29/00, pkt_lp_mode=1 -> 32'h1C_00_29_05, strb 5'h1F, last=1, payload_ready never high.
//  Long DT=0x39 WC=9, payload "123456789" -> 4 words, CRC 16'h6F91 at bytes[2:1] of word 4, strb 4'h7.
//  Long WC=0 -> header word then 32'h0000_FFFF strb 4'h3 last; WC=3/4 cover r=3 spill and r=4 cases.
//  Random iface_data_rqst gaps + payload_valid gaps -> data unchanged while not consumed; underrun pulses counted.
//  Assert rst_n low mid-PAY -> outputs 0 next cycle; next packet after reset is bit-exact.

Source files
------------

// File: rtl/dsi_packet_assembler_if.sv
// rtl/dsi_packet_assembler_if.sv - command, payload and lane-word signals of the DSI packet assembler
interface dsi_packet_assembler_if;
  logic        link_ready;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        pkt_long;
  logic        pkt_lp_mode;
  logic [1:0]  pkt_vc;
  logic [5:0]  pkt_data_type;
  logic [15:0] pkt_word_count;
  logic [31:0] payload_data;
  logic        payload_valid;
  logic        payload_ready;
  logic [31:0] iface_write_data;
  logic [4:0]  iface_write_strb;
  logic        iface_write_rqst;
  logic        iface_last_word;
  logic        iface_data_rqst;
  logic        payload_underrun;

  modport master (
    input  link_ready, pkt_valid, pkt_long, pkt_lp_mode, pkt_vc, pkt_data_type,
           pkt_word_count, payload_data, payload_valid, iface_data_rqst,
    output pkt_ready, payload_ready, iface_write_data, iface_write_strb,
           iface_write_rqst, iface_last_word, payload_underrun
  );

  modport slave (
    output link_ready, pkt_valid, pkt_long, pkt_lp_mode, pkt_vc, pkt_data_type,
           pkt_word_count, payload_data, payload_valid, iface_data_rqst,
    input  pkt_ready, payload_ready, iface_write_data, iface_write_strb,
           iface_write_rqst, iface_last_word, payload_underrun
  );
endinterface

// File: rtl/dsi_packet_assembler.sv
// rtl/dsi_packet_assembler.sv - builds DSI short/long packets (header ECC, payload CRC16) as 32-bit lane words
module dsi_packet_assembler #(
  parameter bit CRC_ENABLE = 1'b1,
  parameter bit ECC_ENABLE = 1'b1
) (
  input  logic                          clk_sys,
  input  logic                          rst_n,
  dsi_packet_assembler_if.master        bus
);

  typedef enum logic [1:0] {IDLE, HDR, PAY, CRC} state_t;

  state_t      state;
  logic        lp_q;
  logic        spill3_q;
  logic [15:0] rem_q;
  logic [15:0] crc_q;
  logic [31:0] data_q;
  logic [4:0]  strb_q;
  logic        rqst_q;
  logic        last_q;

  logic        consume;
  logic        need_word;
  logic        take_word;
  logic [2:0]  nbytes;
  logic        final_word;
  logic [31:0] pay_masked;
  logic [15:0] crc_next;
  logic [15:0] crc_fin;
  logic [15:0] crc_hold;
  logic [23:0] hdr;
  logic [7:0]  ecc;

  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    logic [7:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    p[7:6] = 2'b00;
    return p;
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  assign consume    = rqst_q && bus.iface_data_rqst;
  assign need_word  = (state == HDR || state == PAY) && (rem_q != 16'd0);
  assign take_word  = consume && need_word && bus.payload_valid;
  assign nbytes     = (rem_q >= 16'd4) ? 3'd4 : rem_q[2:0];
  assign final_word = (rem_q <= 16'd4);
  assign hdr        = {bus.pkt_word_count, bus.pkt_vc, bus.pkt_data_type};
  assign ecc        = ECC_ENABLE ? ecc_calc(hdr) : 8'h00;
  assign crc_fin    = CRC_ENABLE ? crc_next : 16'h0000;
  assign crc_hold   = CRC_ENABLE ? crc_q : 16'h0000;

  // Only the bytes that belong to the packet are kept and folded into the CRC.
  always_comb begin
    pay_masked = 32'h0;
    crc_next   = crc_q;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(nbytes)) begin
        pay_masked[8*i +: 8] = bus.payload_data[8*i +: 8];
        crc_next             = crc_byte(crc_next, bus.payload_data[8*i +: 8]);
      end
    end
  end

  assign bus.pkt_ready        = rst_n && (state == IDLE) && bus.pkt_valid && bus.link_ready;
  assign bus.payload_ready    = take_word;
  assign bus.payload_underrun = consume && need_word && !bus.payload_valid;
  assign bus.iface_write_data = data_q;
  assign bus.iface_write_strb = strb_q;
  assign bus.iface_write_rqst = rqst_q;
  assign bus.iface_last_word  = last_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lp_q     <= 1'b0;
      spill3_q <= 1'b0;
      rem_q    <= 16'd0;
      crc_q    <= 16'hFFFF;
      data_q   <= 32'h0;
      strb_q   <= 5'h0;
      rqst_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pkt_ready) begin
            state    <= HDR;
            lp_q     <= bus.pkt_lp_mode;
            spill3_q <= 1'b0;
            rem_q    <= bus.pkt_long ? bus.pkt_word_count : 16'd0;
            crc_q    <= 16'hFFFF;
            data_q   <= {ecc, hdr};
            strb_q   <= {bus.pkt_lp_mode, 4'hF};
            rqst_q   <= 1'b1;
            last_q   <= !bus.pkt_long;
          end
        end
        default: begin
          if (consume) begin
            if (last_q) begin
              state  <= IDLE;
              data_q <= 32'h0;
              strb_q <= 5'h0;
              rqst_q <= 1'b0;
              last_q <= 1'b0;
            end else if (need_word) begin
              // Without a payload word the current word is simply offered again.
              if (take_word) begin
                state  <= PAY;
                rem_q  <= rem_q - {13'd0, nbytes};
                crc_q  <= crc_next;
                strb_q <= {lp_q, 4'hF};
                data_q <= pay_masked;
                if (final_word) begin
                  case (nbytes)
                    3'd1: begin
                      data_q <= {8'h00, crc_fin, pay_masked[7:0]};
                      strb_q <= {lp_q, 4'h7};
                      last_q <= 1'b1;
                    end
                    3'd2: begin
                      data_q <= {crc_fin, pay_masked[15:0]};
                      last_q <= 1'b1;
                    end
                    3'd3: begin
                      data_q   <= {crc_fin[7:0], pay_masked[23:0]};
                      spill3_q <= 1'b1;
                    end
                    default: spill3_q <= 1'b0;
                  endcase
                end
              end
            end else begin
              // Trailing CRC word: high byte after an r=3 spill, else both bytes.
              state  <= CRC;
              last_q <= 1'b1;
              if (spill3_q) begin
                data_q <= {24'h0, crc_hold[15:8]};
                strb_q <= {lp_q, 4'h1};
              end else begin
                data_q <= {16'h0, crc_hold};
                strb_q <= {lp_q, 4'h3};
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// tb/tb_dsi_packet_assembler.sv - directed self-checking bench for dsi_packet_assembler
module tb_dsi_packet_assembler;

  logic clk_sys;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [37:0] exp_q[$];
  logic [31:0] pay_q[$];

  dsi_packet_assembler_if bus();

  dsi_packet_assembler dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [31:0] w, input int n);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8 * n; i++) begin
      if (r[0] ^ w[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic push_exp(input logic last, input logic [4:0] strb, input logic [31:0] data);
    exp_q.push_back({last, strb, data});
  endtask

  task automatic clear_inputs();
    bus.link_ready      = 1'b1;
    bus.pkt_valid       = 1'b0;
    bus.pkt_long        = 1'b0;
    bus.pkt_lp_mode     = 1'b0;
    bus.pkt_vc          = 2'd0;
    bus.pkt_data_type   = 6'd0;
    bus.pkt_word_count  = 16'd0;
    bus.payload_data    = 32'h0;
    bus.payload_valid   = 1'b0;
    bus.iface_data_rqst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"}, bus.iface_write_data, 32'h0);
    check({tag, "_strb"}, bus.iface_write_strb, 5'h0);
    check({tag, "_rqst"}, bus.iface_write_rqst, 1'b0);
    check({tag, "_last"}, bus.iface_last_word, 1'b0);
    check({tag, "_urun"}, bus.payload_underrun, 1'b0);
  endtask

  task automatic run_packet(input string name, input logic lng, input logic lp, input logic [1:0] vc,
                            input logic [5:0] dt, input logic [15:0] wc, input bit gaps, input int abort_at);
    int got, cyc, npay, pops, exp_ur, obs_ur;
    bit accepted, held, consume, ur;
    logic [37:0] cur, prev;
    got = 0; cyc = 0; pops = 0; exp_ur = 0; obs_ur = 0;
    accepted = 0; held = 0; prev = '0;
    npay = pay_q.size();
    while (got < exp_q.size() && cyc < 400 && !(abort_at > 0 && got >= abort_at)) begin
      @(negedge clk_sys);
      cyc++;
      if (!accepted) begin
        bus.pkt_valid      = 1'b1;
        bus.link_ready     = 1'b1;
        bus.pkt_long       = lng;
        bus.pkt_lp_mode    = lp;
        bus.pkt_vc         = vc;
        bus.pkt_data_type  = dt;
        bus.pkt_word_count = wc;
      end else begin
        bus.pkt_valid      = 1'b0;
        bus.link_ready     = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.pkt_long       = 1'($urandom_range(0, 1));
        bus.pkt_lp_mode    = 1'($urandom_range(0, 1));
        bus.pkt_data_type  = 6'($urandom_range(0, 63));
        bus.pkt_word_count = 16'($urandom_range(0, 65535));
      end
      bus.iface_data_rqst = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.payload_valid   = (pay_q.size() != 0) && (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
      bus.payload_data    = (pay_q.size() != 0) ? pay_q[0] : 32'hDEADBEEF;
      #1;
      cur = {bus.iface_last_word, bus.iface_write_strb, bus.iface_write_data};
      if (held) check($sformatf("%s_hold", name), cur, prev);
      if (bus.pkt_ready) accepted = 1;
      consume = bus.iface_write_rqst && bus.iface_data_rqst;
      ur = consume && (got < npay) && !bus.payload_valid;
      if (ur) exp_ur++;
      if (bus.payload_underrun) obs_ur++;
      if (bus.payload_ready) begin
        pops++;
        void'(pay_q.pop_front());
      end
      if (consume && !ur) begin
        check($sformatf("%s_w%0d", name, got), cur, exp_q[got]);
        got++;
      end
      held = bus.iface_write_rqst && !(consume && !ur);
      prev = cur;
    end
    bus.pkt_valid = 1'b0;
    if (cyc >= 400) check($sformatf("%s_timeout_words", name), got, exp_q.size());
    if (abort_at > 0) return;
    check($sformatf("%s_underruns", name), obs_ur, exp_ur);
    check($sformatf("%s_pops", name), pops, npay);
    @(negedge clk_sys);
    bus.iface_data_rqst = 1'b0;
    bus.payload_valid   = 1'b0;
    #1;
    check($sformatf("%s_rqst_drop", name), bus.iface_write_rqst, 1'b0);
  endtask

  task automatic setup_wc9();
    exp_q.delete(); pay_q.delete();
    pay_q.push_back(32'h34333231);
    pay_q.push_back(32'h38373635);
    pay_q.push_back(32'hAABBCC39);
    push_exp(1'b0, 5'h0F, 32'h30000939);
    push_exp(1'b0, 5'h0F, 32'h34333231);
    push_exp(1'b0, 5'h0F, 32'h38373635);
    push_exp(1'b1, 5'h07, 32'h006F9139);
  endtask

  initial begin
    logic [15:0] c;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk_sys);
    #1;
    check_idle_outputs("reset");
    check("reset_pkt_ready", bus.pkt_ready, 1'b0);
    rst_n = 1'b1;

    // A command is held off while the link is down.
    @(negedge clk_sys);
    bus.pkt_valid = 1'b1; bus.link_ready = 1'b0; bus.pkt_data_type = 6'h05; bus.pkt_word_count = 16'h0011;
    #1;
    check("linkdown_pkt_ready", bus.pkt_ready, 1'b0);
    @(negedge clk_sys);
    #1;
    check("linkdown_rqst", bus.iface_write_rqst, 1'b0);
    clear_inputs();

    exp_q.delete(); pay_q.delete();
    push_exp(1'b1, 5'h0F, 32'h36001105);
    run_packet("short_05_11", 1'b0, 1'b0, 2'd0, 6'h05, 16'h0011, 1'b0, 0);

    exp_q.delete(); pay_q.delete();
    push_exp(1'b1, 5'h1F, 32'h1C002905);
    run_packet("short_lp_29", 1'b0, 1'b1, 2'd0, 6'h05, 16'h0029, 1'b0, 0);

    exp_q.delete(); pay_q.delete();
    push_exp(1'b1, 5'h0F, 32'h2F001185);
    run_packet("short_vc2", 1'b0, 1'b0, 2'd2, 6'h05, 16'h0011, 1'b1, 0);

    setup_wc9();
    run_packet("long_wc9", 1'b1, 1'b0, 2'd0, 6'h39, 16'd9, 1'b0, 0);

    exp_q.delete(); pay_q.delete();
    push_exp(1'b0, 5'h0F, 32'h0F000039);
    push_exp(1'b1, 5'h03, 32'h0000FFFF);
    run_packet("long_wc0", 1'b1, 1'b0, 2'd0, 6'h39, 16'd0, 1'b0, 0);

    exp_q.delete(); pay_q.delete();
    c = ref_crc(16'hFFFF, 32'h00003231, 2);
    pay_q.push_back(32'hEEFF3231);
    push_exp(1'b0, 5'h0F, 32'h13000239);
    push_exp(1'b1, 5'h0F, {c, 16'h3231});
    run_packet("long_wc2", 1'b1, 1'b0, 2'd0, 6'h39, 16'd2, 1'b0, 0);

    exp_q.delete(); pay_q.delete();
    c = ref_crc(16'hFFFF, 32'h00333231, 3);
    pay_q.push_back(32'hDD333231);
    push_exp(1'b0, 5'h1F, 32'h09000339);
    push_exp(1'b0, 5'h1F, {c[7:0], 24'h333231});
    push_exp(1'b1, 5'h11, {24'h0, c[15:8]});
    run_packet("long_wc3_lp", 1'b1, 1'b1, 2'd0, 6'h39, 16'd3, 1'b1, 0);

    exp_q.delete(); pay_q.delete();
    c = ref_crc(16'hFFFF, 32'h34333231, 4);
    pay_q.push_back(32'h34333231);
    push_exp(1'b0, 5'h0F, 32'h2C000439);
    push_exp(1'b0, 5'h0F, 32'h34333231);
    push_exp(1'b1, 5'h03, {16'h0, c});
    run_packet("long_wc4", 1'b1, 1'b0, 2'd0, 6'h39, 16'd4, 1'b0, 0);

    setup_wc9();
    run_packet("gaps_wc9", 1'b1, 1'b0, 2'd0, 6'h39, 16'd9, 1'b1, 0);

    // Reset in the middle of the payload, then the same packet must come out intact.
    setup_wc9();
    run_packet("abort_wc9", 1'b1, 1'b0, 2'd0, 6'h39, 16'd9, 1'b0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst_async");
    clear_inputs();
    @(negedge clk_sys);
    #1;
    check_idle_outputs("midrst_cycle");
    rst_n = 1'b1;
    setup_wc9();
    run_packet("after_rst_wc9", 1'b1, 1'b0, 2'd0, 6'h39, 16'd9, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
